// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// State encoding, requester limits and default acknowledge timeout.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2
    } arb_state_t;

    localparam int N_REQ_MAX   = 4;
    localparam int PTR_W       = $clog2(N_REQ_MAX);
    localparam int TIMEOUT_DEF = 64;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping around, plus a flag telling whether any request is set.
module uart_rr_pick
    import uart_arb_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [PTR_W-1:0] win,
    output logic             valid
);

    logic [N_REQ_MAX-1:0] req_x;
    logic [PTR_W-1:0]     idx;

    assign req_x = N_REQ_MAX'(req);

    // Scan from farthest to nearest so the nearest hit is written last.
    always_comb begin
        win   = '0;
        idx   = '0;
        valid = |req;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = PTR_W'((int'(ptr) + i) % N_REQ);
            if (req_x[idx]) begin
                win = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin sharing of one UART TX engine between N_REQ byte sources.
// Define UART_ARB_LOCK_EN to add i_last and keep a winner locked until its last byte.
module uart_tx_arb
    import uart_arb_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   i_req,
`ifdef UART_ARB_LOCK_EN
    input  logic [N_REQ-1:0]   i_last,
`endif
    input  logic [8*N_REQ-1:0] i_data,
    output logic [N_REQ-1:0]   o_gnt,
    output logic [7:0]         o_tx,
    output logic               o_tx_start,
    input  logic               i_tx_busy,
    input  logic               i_tx_start_clear,
    output logic               o_busy,
    output logic               o_err_to,
    input  logic               i_err_clr,
    output logic [CNT_W-1:0]   o_byte_cnt
);

    localparam int TO_W = $clog2(TIMEOUT);

    arb_state_t       state, state_d;
    logic [PTR_W-1:0] ptr, ptr_d;
    logic [TO_W-1:0]  to_cnt, to_cnt_d;
    logic [N_REQ-1:0] gnt_d;
    logic [7:0]       tx_d;
    logic             start_d;
    logic             err_d;
    logic [CNT_W-1:0] bcnt_d;
    logic [N_REQ-1:0] req_eff;
    logic [PTR_W-1:0] win;
    logic             win_vld;
    logic [7:0]       data_arr [N_REQ_MAX];

    for (genvar k = 0; k < N_REQ_MAX; k++) begin : g_data
        if (k < N_REQ) begin : g_used
            assign data_arr[k] = i_data[8*k +: 8];
        end else begin : g_pad
            assign data_arr[k] = '0;
        end
    end

`ifdef UART_ARB_LOCK_EN
    logic                 lock, lock_d;
    logic [PTR_W-1:0]     lock_id, lock_id_d;
    logic [N_REQ_MAX-1:0] last_x;

    assign last_x  = N_REQ_MAX'(i_last);
    assign req_eff = lock ? (i_req & (N_REQ'(1) << lock_id)) : i_req;
`else
    assign req_eff = i_req;
`endif

    uart_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req   (req_eff),
        .ptr   (ptr),
        .win   (win),
        .valid (win_vld)
    );

    assign o_busy = (state != IDLE);

    always_comb begin
        state_d  = state;
        ptr_d    = ptr;
        to_cnt_d = to_cnt;
        gnt_d    = '0;
        tx_d     = o_tx;
        start_d  = o_tx_start;
        err_d    = o_err_to & ~i_err_clr;
        bcnt_d   = o_byte_cnt;
`ifdef UART_ARB_LOCK_EN
        lock_d    = lock;
        lock_id_d = lock_id;
`endif
        unique case (state)
            IDLE: begin
                if (win_vld) begin
                    gnt_d    = N_REQ'(1) << win;
                    tx_d     = data_arr[win];
                    start_d  = 1'b1;
                    ptr_d    = (win == PTR_W'(N_REQ - 1)) ? '0 : win + 1'b1;
                    to_cnt_d = '0;
                    state_d  = START;
`ifdef UART_ARB_LOCK_EN
                    lock_d    = ~last_x[win];
                    lock_id_d = win;
`endif
                end
            end
            START: begin
                if (i_tx_start_clear || i_tx_busy) begin
                    start_d = 1'b0;
                    state_d = WAIT_DONE;
                end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                    // Engine never took the byte: drop it and flag it.
                    start_d = 1'b0;
                    err_d   = 1'b1;
                    state_d = IDLE;
`ifdef UART_ARB_LOCK_EN
                    lock_d  = 1'b0;
`endif
                end else begin
                    to_cnt_d = to_cnt + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!i_tx_busy) begin
                    state_d = IDLE;
                    bcnt_d  = o_byte_cnt + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            to_cnt     <= '0;
            o_gnt      <= '0;
            o_tx       <= '0;
            o_tx_start <= 1'b0;
            o_err_to   <= 1'b0;
            o_byte_cnt <= '0;
`ifdef UART_ARB_LOCK_EN
            lock       <= 1'b0;
            lock_id    <= '0;
`endif
        end else begin
            state      <= state_d;
            ptr        <= ptr_d;
            to_cnt     <= to_cnt_d;
            o_gnt      <= gnt_d;
            o_tx       <= tx_d;
            o_tx_start <= start_d;
            o_err_to   <= err_d;
            o_byte_cnt <= bcnt_d;
`ifdef UART_ARB_LOCK_EN
            lock       <= lock_d;
            lock_id    <= lock_id_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed self-checking bench for uart_tx_arb (4 requesters, short timeout,
// 8-bit byte counter so wrap-around is reachable quickly).
module tb_uart_tx_arb;

    localparam int NR = 4;
    localparam int TO = 8;
    localparam int CW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   i_req;
`ifdef UART_ARB_LOCK_EN
    logic [NR-1:0]   i_last;
`endif
    logic [8*NR-1:0] i_data;
    logic [NR-1:0]   o_gnt;
    logic [7:0]      o_tx;
    logic            o_tx_start;
    logic            i_tx_busy;
    logic            i_tx_start_clear;
    logic            o_busy;
    logic            o_err_to;
    logic            i_err_clr;
    logic [CW-1:0]   o_byte_cnt;

    int checks   = 0;
    int failures = 0;
    int n_hi;

    uart_tx_arb #(.N_REQ(NR), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk              (clk),
        .rst              (rst),
        .i_req            (i_req),
`ifdef UART_ARB_LOCK_EN
        .i_last           (i_last),
`endif
        .i_data           (i_data),
        .o_gnt            (o_gnt),
        .o_tx             (o_tx),
        .o_tx_start       (o_tx_start),
        .i_tx_busy        (i_tx_busy),
        .i_tx_start_clear (i_tx_start_clear),
        .o_busy           (o_busy),
        .o_err_to         (o_err_to),
        .i_err_clr        (i_err_clr),
        .o_byte_cnt       (o_byte_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full byte: grant, start held clr_dly cycles, busy for busy_len cycles.
    task automatic do_byte(input logic [NR-1:0] g, input logic [7:0] d,
                           input int clr_dly, input int busy_len,
                           input bit hold, input logic [CW-1:0] cnt_exp);
        step();
        check("gnt", o_gnt, g);
        check("tx", o_tx, d);
        check("start_rise", o_tx_start, 1);
        if (!hold) i_req = i_req & ~g;
        if (clr_dly > 1) begin
            repeat (clr_dly - 1) step();
            check("start_hold", o_tx_start, 1);
            check("tx_stable", o_tx, d);
        end
        i_tx_start_clear = 1'b1;
        i_tx_busy        = (busy_len > 0);
        step();
        i_tx_start_clear = 1'b0;
        check("start_drop", o_tx_start, 0);
        check("gnt_pulse", o_gnt, 0);
        check("busy_wait", o_busy, 1);
        if (busy_len > 1) repeat (busy_len - 1) step();
        i_tx_busy = 1'b0;
        step();
        check("idle_after", o_busy, 0);
        check("byte_cnt", o_byte_cnt, cnt_exp);
    endtask

    // Let the timeout expire; n counts cycles with start high.
    task automatic to_run(output int n);
        n = 0;
        step();
        i_req = '0;
        while (o_tx_start && n < 20) begin
            n++;
            step();
        end
    endtask

    initial begin
        rst              = 1'b1;
        i_req            = '0;
        i_data           = '0;
        i_tx_busy        = 1'b0;
        i_tx_start_clear = 1'b0;
        i_err_clr        = 1'b0;
`ifdef UART_ARB_LOCK_EN
        i_last           = '1;
`endif
        step();
        step();
        check("rst_gnt", o_gnt, 0);
        check("rst_tx", o_tx, 0);
        check("rst_start", o_tx_start, 0);
        check("rst_busy", o_busy, 0);
        check("rst_err", o_err_to, 0);
        check("rst_cnt", o_byte_cnt, 0);
        rst = 1'b0;

        // Single requester 0, start held 2 cycles, busy 10 cycles.
        i_data = 32'h0000_0041;
        i_req  = 4'b0001;
        do_byte(4'b0001, 8'h41, 2, 10, 1'b0, 1);
        step();
        check("t1_no_regrant", o_gnt, 0);

        rst = 1'b1;
        step();
        rst = 1'b0;

        // Two requesters held continuously alternate.
        i_data = 32'h0000_2211;
        i_req  = 4'b0011;
        do_byte(4'b0001, 8'h11, 2, 3, 1'b1, 1);
        do_byte(4'b0010, 8'h22, 2, 3, 1'b1, 2);
        do_byte(4'b0001, 8'h11, 1, 2, 1'b1, 3);
        do_byte(4'b0010, 8'h22, 1, 2, 1'b1, 4);
        i_req = '0;

        // Unresponsive TX: timeout after TO cycles of start.
        i_req = 4'b0001;
        to_run(n_hi);
        check("to_start_cycles", n_hi, TO);
        check("to_err_set", o_err_to, 1);
        check("to_idle", o_busy, 0);
        check("to_cnt_same", o_byte_cnt, 4);
        step();
        check("to_err_sticky", o_err_to, 1);
        i_err_clr = 1'b1;
        step();
        i_err_clr = 1'b0;
        check("err_clear", o_err_to, 0);

        // Clear held across a second timeout: set wins.
        i_err_clr = 1'b1;
        i_req     = 4'b0001;
        to_run(n_hi);
        check("to2_start_cycles", n_hi, TO);
        check("set_wins", o_err_to, 1);
        i_err_clr = 1'b0;
        step();
        check("to2_err_keep", o_err_to, 1);

        // Reset while in WAIT_DONE.
        i_req = 4'b0010;
        step();
        check("t4_gnt", o_gnt, 4'b0010);
        i_req            = '0;
        i_tx_start_clear = 1'b1;
        i_tx_busy        = 1'b1;
        step();
        i_tx_start_clear = 1'b0;
        check("t4_waitdone", o_busy, 1);
        rst = 1'b1;
        step();
        check("t4_rst_gnt", o_gnt, 0);
        check("t4_rst_tx", o_tx, 0);
        check("t4_rst_start", o_tx_start, 0);
        check("t4_rst_busy", o_busy, 0);
        check("t4_rst_err", o_err_to, 0);
        check("t4_rst_cnt", o_byte_cnt, 0);
        rst       = 1'b0;
        i_tx_busy = 1'b0;
        i_req     = 4'b0010;
        do_byte(4'b0010, 8'h22, 1, 3, 1'b0, 1);

        // Requester 3 alone, pointer wraps back to 0.
        rst = 1'b1;
        step();
        rst    = 1'b0;
        i_data = 32'h5A00_2211;
        i_req  = 4'b1000;
        do_byte(4'b1000, 8'h5A, 1, 2, 1'b0, 1);
        i_req = 4'b0011;
        do_byte(4'b0001, 8'h11, 1, 0, 1'b0, 2);
        i_req = '0;

        // Byte counter wrap 0xFF -> 0x00.
        i_req = 4'b0001;
        for (int b = 3; b <= 258; b++) begin
            do_byte(4'b0001, 8'h11, 1, 0, 1'b1, CW'(b));
        end
        i_req = '0;
        check("cnt_wrapped", o_byte_cnt, 2);

`ifdef UART_ARB_LOCK_EN
        // Lock: req0 bytes with last=0,0,1 while req1 waits.
        rst = 1'b1;
        step();
        rst    = 1'b0;
        i_last = 4'b0010;
        i_req  = 4'b0011;
        do_byte(4'b0001, 8'h11, 1, 1, 1'b1, 1);
        do_byte(4'b0001, 8'h11, 1, 1, 1'b1, 2);
        i_last = 4'b0011;
        do_byte(4'b0001, 8'h11, 1, 1, 1'b1, 3);
        do_byte(4'b0010, 8'h22, 1, 1, 1'b1, 4);
        i_req = '0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
